// File: rtl/seg7_pkg.sv
// Shared types and the 7-segment decode table for the BCD scan counter.
//   bcd_t        4-bit BCD digit
//   SEG_BLANK    all segments off (active-low gfedcba)
//   SEG_LUT      active-low gfedcba patterns for digits 0..9
//   seg7_decode  BCD digit -> segment pattern, blank for non-BCD codes
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg7_decode(input bcd_t d);
    if (d <= 4'd9) begin
      seg7_decode = SEG_LUT[d];
    end else begin
      seg7_decode = SEG_BLANK;
    end
  endfunction

endpackage

// File: rtl/seg7_bcd_digit.sv
// One BCD digit of the ripple counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   step        count strobe for this cycle (prescaler tick AND enable)
//   dir         0 = up, 1 = down
//   clr         synchronous clear to 0, dominates step
//   carry_in    carry/borrow from the next lower digit (1 for digit 0)
//   q           current digit value
//   carry_out   carry/borrow to the next higher digit (combinational)
module seg7_bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  input  logic dir,
  input  logic clr,
  input  logic carry_in,
  output bcd_t q,
  output logic carry_out
);

  bcd_t q_q, q_d;
  logic at_limit;

  // A digit passes carry/borrow on when it is about to roll over.
  assign at_limit  = dir ? (q_q == 4'd0) : (q_q == 4'd9);
  assign carry_out = carry_in & at_limit;
  assign q         = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (step && carry_in) begin
      if (dir) begin
        q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
      end else begin
        q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/seg7_bcd_scan_counter.sv
// NDIG-digit BCD up/down counter with a multiplexed 7-segment driver.
//   CLK    system clock          RST_X  asynchronous active-low reset
//   EN     count enable          CLR    synchronous clear (beats a tick)
//   DOWN   count direction       SEG    segments gfedcba, active-low, registered
//   AN     anodes, one-hot low   DP     decimal point, always off
//   WRAP   one-cycle wrap pulse  VALUE  BCD count, digit i at [4i+3:4i]
// Build option: define SEG7_LZB_EN for leading-zero blanking of digits above 0.
module seg7_bcd_scan_counter
  import seg7_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 52428800,
  parameter int SCAN_DIV = 65536
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              EN,
  input  logic              CLR,
  input  logic              DOWN,
  output logic [6:0]        SEG,
  output logic [NDIG-1:0]   AN,
  output logic              DP,
  output logic              WRAP,
  output logic [4*NDIG-1:0] VALUE
);

  localparam int PC_W  = $clog2(TICK_DIV);
  localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic             wrap_q, wrap_d;

  logic             tick;
  logic             step;
  logic [NDIG:0]    carry;
  bcd_t             digit [NDIG];

  assign tick     = (pc_q == PC_W'(TICK_DIV - 1));
  assign step     = tick & EN;
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      seg7_bcd_digit u_digit (
        .clk       (CLK),
        .rst_n     (RST_X),
        .step      (step),
        .dir       (DOWN),
        .clr       (CLR),
        .carry_in  (carry[gi]),
        .q         (digit[gi]),
        .carry_out (carry[gi+1])
      );
      assign VALUE[4*gi +: 4] = digit[gi];
    end
  endgenerate

`ifdef SEG7_LZB_EN
  // hi_zero[i]: digit i and every digit above it are zero.
  logic [NDIG-1:0] hi_zero;
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_lzb
      if (gi == NDIG - 1) begin : g_top
        assign hi_zero[gi] = (digit[gi] == 4'd0);
      end else begin : g_mid
        assign hi_zero[gi] = (digit[gi] == 4'd0) & hi_zero[gi+1];
      end
    end
  endgenerate
`endif

  always_comb begin
    pc_d   = (tick) ? '0 : pc_q + PC_W'(1);
    // A carry out of the top digit on a counting step is the full wrap.
    wrap_d = step & carry[NDIG] & ~CLR;
    if (CLR) begin
      pc_d = '0;
    end

    sc_d  = sc_q + SC_W'(1);
    idx_d = idx_q;
    if (sc_q == SC_W'(SCAN_DIV - 1)) begin
      sc_d  = '0;
      idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    an_d         = '1;
    an_d[idx_q]  = 1'b0;
    seg_d        = seg7_decode(digit[idx_q]);
`ifdef SEG7_LZB_EN
    if ((idx_q != '0) && hi_zero[idx_q]) begin
      seg_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      pc_q   <= '0;
      sc_q   <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      sc_q   <= sc_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      wrap_q <= wrap_d;
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign DP   = 1'b1;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_seg7_bcd_scan_counter.sv
// Directed bench for seg7_bcd_scan_counter with NDIG=2, TICK_DIV=4, SCAN_DIV=2.
// A small decimal model predicts every cycle; predictions go through a queue.
module tb_seg7_bcd_scan_counter;

  logic       CLK = 1'b0;
  logic       RST_X = 1'b1;
  logic       EN = 1'b0;
  logic       CLR = 1'b0;
  logic       DOWN = 1'b0;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       DP;
  logic       WRAP;
  logic [7:0] VALUE;

  seg7_bcd_scan_counter #(
    .NDIG     (2),
    .TICK_DIV (4),
    .SCAN_DIV (2)
  ) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .EN    (EN),
    .CLR   (CLR),
    .DOWN  (DOWN),
    .SEG   (SEG),
    .AN    (AN),
    .DP    (DP),
    .WRAP  (WRAP),
    .VALUE (VALUE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] value;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] an;
  } exp_t;

  exp_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  // Model state: prescaler, decimal count 0..99, scan counter/index.
  int   m_pc, m_val, m_sc, m_idx;
  logic m_wrap;

  function automatic logic [6:0] dec7(input int d);
    case (d)
      0: dec7 = 7'h40;  1: dec7 = 7'h79;  2: dec7 = 7'h24;  3: dec7 = 7'h30;
      4: dec7 = 7'h19;  5: dec7 = 7'h12;  6: dec7 = 7'h02;  7: dec7 = 7'h78;
      8: dec7 = 7'h00;  9: dec7 = 7'h10;
      default: dec7 = 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_val = 0; m_sc = 0; m_idx = 0; m_wrap = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, compare at the next negedge.
  task automatic cycle(input logic en, input logic down, input logic clr);
    exp_t e, got;
    int   dig;
    logic tick;
    EN = en; DOWN = down; CLR = clr;

    dig   = (m_idx == 0) ? (m_val % 10) : (m_val / 10);
    e.seg = dec7(dig);
`ifdef SEG7_LZB_EN
    if (m_idx == 1 && (m_val / 10) == 0) e.seg = 7'h7F;
`endif
    e.an = (m_idx == 0) ? 2'b10 : 2'b01;

    tick   = (m_pc == 3);
    m_wrap = 1'b0;
    if (clr) begin
      m_val = 0;
      m_pc  = 0;
    end else begin
      m_pc = tick ? 0 : m_pc + 1;
      if (tick && en) begin
        if (!down) begin
          if (m_val == 99) begin m_val = 0; m_wrap = 1'b1; end
          else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin m_val = 99; m_wrap = 1'b1; end
          else m_val = m_val - 1;
        end
      end
    end
    if (m_sc == 1) begin
      m_sc  = 0;
      m_idx = (m_idx == 1) ? 0 : 1;
    end else begin
      m_sc = m_sc + 1;
    end

    e.value = to_bcd(m_val);
    e.wrap  = m_wrap;
    exp_q.push_back(e);

    @(negedge CLK);
    ncyc++;
    got = exp_q.pop_front();
    $display("cyc %0d en=%b down=%b clr=%b value=%h wrap=%b seg=%h an=%b",
             ncyc, en, down, clr, VALUE, WRAP, SEG, AN);
    chk("value", {24'd0, VALUE}, {24'd0, got.value});
    chk("wrap",  {31'd0, WRAP},  {31'd0, got.wrap});
    chk("seg",   {25'd0, SEG},   {25'd0, got.seg});
    chk("an",    {30'd0, AN},    {30'd0, got.an});
    chk("an_onehot", 32'($countones(~AN)), 32'd1);
    chk("dp",    {31'd0, DP},    32'd1);
  endtask

  // Advance (without counting) until the next cycle driven is a tick.
  task automatic run_to_tick(input logic en, input logic down);
    for (int i = 0; i < 8 && m_pc != 3; i++) cycle(en, down, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_seg"},   {25'd0, SEG},   32'h7F);
    chk({tag, "_an"},    {30'd0, AN},    32'h3);
    chk({tag, "_wrap"},  {31'd0, WRAP},  32'd0);
    chk({tag, "_value"}, {24'd0, VALUE}, 32'd0);
    chk({tag, "_dp"},    {31'd0, DP},    32'd1);
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect immediately.
    #2 RST_X = 1'b0;
    #1 check_reset_values("reset");
    @(negedge CLK);
    RST_X = 1'b1;
    model_reset();

    // Count up from release: steps at cycles 4, 8, 12.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("value_after_12", {24'd0, VALUE}, 32'h03);

    // Count up to 99, then wrap to 00.
    for (int i = 0; i < 600 && m_val != 99; i++) cycle(1'b1, 1'b0, 1'b0);
    run_to_tick(1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("wrap_up_value", {24'd0, VALUE}, 32'h00);
    chk("wrap_up_pulse", {31'd0, WRAP}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("wrap_up_pulse_end", {31'd0, WRAP}, 32'd0);

    // Count down from 00: wrap to 99.
    run_to_tick(1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    chk("wrap_dn_value", {24'd0, VALUE}, 32'h99);
    chk("wrap_dn_pulse", {31'd0, WRAP}, 32'd1);

    // Borrow through digits: 10 -> 09.
    for (int i = 0; i < 600 && m_val != 10; i++) cycle(1'b1, 1'b1, 1'b0);
    run_to_tick(1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    chk("borrow_value", {24'd0, VALUE}, 32'h09);
    chk("borrow_nowrap", {31'd0, WRAP}, 32'd0);

    // Up to 42, then CLR in the tick cycle.
    for (int i = 0; i < 600 && m_val != 42; i++) cycle(1'b1, 1'b0, 1'b0);
    run_to_tick(1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("clr_value", {24'd0, VALUE}, 32'h00);
    chk("clr_nowrap", {31'd0, WRAP}, 32'd0);
    // Prescaler restarted: three quiet cycles, step on the fourth.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("clr_pc_hold", {24'd0, VALUE}, 32'h00);
    cycle(1'b1, 1'b0, 1'b0);
    chk("clr_pc_step", {24'd0, VALUE}, 32'h01);

    // Up to 07, then hold with EN=0 across 3 ticks while scanning.
    for (int i = 0; i < 100 && m_val != 7; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("en0_hold", {24'd0, VALUE}, 32'h07);

    // Reset mid-count, then counting restarts from 0.
    @(posedge CLK);
    #2 RST_X = 1'b0;
    #1 check_reset_values("mid_reset");
    @(negedge CLK);
    RST_X = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("restart_value", {24'd0, VALUE}, 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
